// File: rtl/robo_ambiente.sv
// Grid-world environment for a cleaning robot: holds the map, the robot pose and its sensors.
// Debris handling (barrier, remover, timed removal) is built only with ROBO_AMBIENTE_ENTULHO_EN.
module robo_ambiente #(
    parameter int         LINHAS  = 10,
    parameter int         COLUNAS = 20,
    parameter int         LIN_INI = 0,
    parameter int         COL_INI = 0,
    parameter logic [1:0] ORI_INI = 2'b00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       carga,
    input  logic       map_we,
    input  logic [3:0] map_lin,
    input  logic [4:0] map_col,
    input  logic [3:0] map_dado,
    input  logic       avancar,
    input  logic       girar,
    input  logic       remover,
    output logic       head,
    output logic       left,
    output logic       under,
    output logic       barrier,
    output logic [3:0] linha,
    output logic [4:0] coluna,
    output logic [1:0] orientacao,
    output logic       removendo,
    output logic       anomalia
);
    localparam logic [1:0] ST_CARGA  = 2'd0;
    localparam logic [1:0] ST_OPERA  = 2'd1;
    localparam logic [1:0] ST_REMOVE = 2'd2;
    localparam logic [1:0] ST_ANOM   = 2'd3;

    localparam logic [1:0] ORI_N = 2'b00;
    localparam logic [1:0] ORI_S = 2'b01;
    localparam logic [1:0] ORI_L = 2'b10;
    localparam logic [1:0] ORI_O = 2'b11;

    localparam logic [4:0] LIN_N   = 5'(LINHAS);
    localparam logic [5:0] COL_N   = 6'(COLUNAS);
    localparam logic [3:0] LIN_MAX = 4'(LINHAS - 1);
    localparam logic [4:0] COL_MAX = 5'(COLUNAS - 1);
    localparam logic [3:0] LIN_I   = 4'(LIN_INI);
    localparam logic [4:0] COL_I   = 5'(COL_INI);

    logic [1:0] state_q, state_d;
    logic [3:0] lin_q, lin_d;
    logic [4:0] col_q, col_d;
    logic [1:0] ori_q, ori_d;
    logic [3:0] map_q [LINHAS][COLUNAS];

    logic       wr_en;
    logic [3:0] wr_lin, wr_dat;
    logic [4:0] wr_col;

    logic       f_ok, l_ok;
    logic [3:0] f_lin, l_lin;
    logic [4:0] f_col, l_col;
    logic [3:0] f_code, l_code, cur_code;

`ifdef ROBO_AMBIENTE_ENTULHO_EN
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] cap_lin_q, cap_lin_d;
    logic [4:0] cap_col_q, cap_col_d;

    function automatic logic is_deb(input logic [3:0] c);
        return (c >= 4'd3) && (c <= 4'd5);
    endfunction
`endif

    // Front and left neighbours; off-map neighbours fall back to the current cell for the read.
    always_comb begin
        f_ok = 1'b1; f_lin = lin_q; f_col = col_q;
        l_ok = 1'b1; l_lin = lin_q; l_col = col_q;
        case (ori_q)
            ORI_N: begin
                f_ok = (lin_q != 4'd0);    f_lin = lin_q - 4'd1;
                l_ok = (col_q != 5'd0);    l_col = col_q - 5'd1;
            end
            ORI_S: begin
                f_ok = (lin_q != LIN_MAX); f_lin = lin_q + 4'd1;
                l_ok = (col_q != COL_MAX); l_col = col_q + 5'd1;
            end
            ORI_L: begin
                f_ok = (col_q != COL_MAX); f_col = col_q + 5'd1;
                l_ok = (lin_q != 4'd0);    l_lin = lin_q - 4'd1;
            end
            default: begin
                f_ok = (col_q != 5'd0);    f_col = col_q - 5'd1;
                l_ok = (lin_q != LIN_MAX); l_lin = lin_q + 4'd1;
            end
        endcase
        if (!f_ok) begin f_lin = lin_q; f_col = col_q; end
        if (!l_ok) begin l_lin = lin_q; l_col = col_q; end
    end

    assign f_code   = map_q[f_lin][f_col];
    assign l_code   = map_q[l_lin][l_col];
    assign cur_code = map_q[lin_q][col_q];

    assign head  = !f_ok || (f_code == 4'd1);
    assign left  = !l_ok || (l_code == 4'd1);
    assign under = (cur_code == 4'd2);
`ifdef ROBO_AMBIENTE_ENTULHO_EN
    assign barrier   = f_ok && is_deb(f_code);
    assign removendo = (state_q == ST_REMOVE);
`else
    assign barrier   = 1'b0;
    assign removendo = 1'b0;
`endif
    assign anomalia   = (state_q == ST_ANOM);
    assign linha      = lin_q;
    assign coluna     = col_q;
    assign orientacao = ori_q;

    always_comb begin
        state_d = state_q;
        lin_d   = lin_q;
        col_d   = col_q;
        ori_d   = ori_q;
        wr_en   = 1'b0;
        wr_lin  = map_lin;
        wr_col  = map_col;
        wr_dat  = map_dado;
`ifdef ROBO_AMBIENTE_ENTULHO_EN
        cnt_d     = cnt_q;
        cap_lin_d = cap_lin_q;
        cap_col_d = cap_col_q;
`endif
        case (state_q)
            ST_CARGA: begin
                lin_d = LIN_I; col_d = COL_I; ori_d = ORI_INI;
                wr_en = map_we && ({1'b0, map_lin} < LIN_N) && ({1'b0, map_col} < COL_N);
                if (!carga)
                    state_d = (map_q[LIN_I][COL_I] == 4'd1) ? ST_ANOM : ST_OPERA;
            end
            ST_OPERA: begin
                if (carga) begin
                    state_d = ST_CARGA;
                    lin_d = LIN_I; col_d = COL_I; ori_d = ORI_INI;
                end else if (avancar) begin
                    if (head || barrier) state_d = ST_ANOM;
                    else begin lin_d = f_lin; col_d = f_col; end
                end else if (girar) begin
                    case (ori_q)
                        ORI_N:   ori_d = ORI_O;
                        ORI_O:   ori_d = ORI_S;
                        ORI_S:   ori_d = ORI_L;
                        default: ori_d = ORI_N;
                    endcase
`ifdef ROBO_AMBIENTE_ENTULHO_EN
                end else if (remover && barrier) begin
                    // Removal time scales with debris weight: 3 cycles per level.
                    cnt_d     = (f_code == 4'd3) ? 4'd3 : (f_code == 4'd4) ? 4'd6 : 4'd9;
                    cap_lin_d = f_lin;
                    cap_col_d = f_col;
                    state_d   = ST_REMOVE;
`endif
                end
            end
`ifdef ROBO_AMBIENTE_ENTULHO_EN
            ST_REMOVE: begin
                if (carga) begin
                    state_d = ST_CARGA;
                    cnt_d   = 4'd0;
                    lin_d = LIN_I; col_d = COL_I; ori_d = ORI_INI;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        wr_en   = 1'b1;
                        wr_lin  = cap_lin_q;
                        wr_col  = cap_col_q;
                        wr_dat  = 4'd0;
                        state_d = ST_OPERA;
                    end
                end
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_CARGA;
            lin_q   <= LIN_I;
            col_q   <= COL_I;
            ori_q   <= ORI_INI;
            for (int i = 0; i < LINHAS; i++)
                for (int j = 0; j < COLUNAS; j++)
                    map_q[i][j] <= 4'd0;
`ifdef ROBO_AMBIENTE_ENTULHO_EN
            cnt_q     <= 4'd0;
            cap_lin_q <= 4'd0;
            cap_col_q <= 5'd0;
`endif
        end else begin
            state_q <= state_d;
            lin_q   <= lin_d;
            col_q   <= col_d;
            ori_q   <= ori_d;
            if (wr_en) map_q[wr_lin][wr_col] <= wr_dat;
`ifdef ROBO_AMBIENTE_ENTULHO_EN
            cnt_q     <= cnt_d;
            cap_lin_q <= cap_lin_d;
            cap_col_q <= cap_col_d;
`endif
        end
    end
endmodule

// File: tb/tb_robo_ambiente.sv
// Directed bench for robo_ambiente: walks the robot through a small hand-built map.
module tb_robo_ambiente;
    logic       clock = 1'b0;
    logic       reset, carga, map_we, avancar, girar, remover;
    logic [3:0] map_lin, map_dado;
    logic [4:0] map_col;
    logic       head, left, under, barrier, removendo, anomalia;
    logic [3:0] linha;
    logic [4:0] coluna;
    logic [1:0] orientacao;

    int total  = 0;
    int passed = 0;

`ifdef ROBO_AMBIENTE_ENTULHO_EN
    localparam logic [3:0] DEB = 4'd4;
`else
    localparam logic [3:0] DEB = 4'd5;
`endif

    robo_ambiente dut (
        .clock(clock), .reset(reset), .carga(carga), .map_we(map_we),
        .map_lin(map_lin), .map_col(map_col), .map_dado(map_dado),
        .avancar(avancar), .girar(girar), .remover(remover),
        .head(head), .left(left), .under(under), .barrier(barrier),
        .linha(linha), .coluna(coluna), .orientacao(orientacao),
        .removendo(removendo), .anomalia(anomalia)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic load(input logic [3:0] l, input logic [4:0] c, input logic [3:0] d);
        map_we = 1'b1; map_lin = l; map_col = c; map_dado = d;
        tick();
        map_we = 1'b0;
    endtask

    initial begin
        reset = 1'b0; carga = 1'b1; map_we = 1'b0; map_lin = '0; map_col = '0; map_dado = '0;
        avancar = 1'b0; girar = 1'b0; remover = 1'b0;
        #12;
        chk("rst_linha", 8'(linha), 8'd0);
        chk("rst_coluna", 8'(coluna), 8'd0);
        chk("rst_ori", 8'(orientacao), 8'd0);
        chk("rst_head", 8'(head), 8'd1);
        chk("rst_left", 8'(left), 8'd1);
        chk("rst_under", 8'(under), 8'd0);
        chk("rst_barrier", 8'(barrier), 8'd0);
        chk("rst_anom", 8'(anomalia), 8'd0);
        chk("rst_remov", 8'(removendo), 8'd0);

        reset = 1'b1;
        tick();
        load(4'd2, 5'd5, 4'd1);
        load(4'd1, 5'd0, 4'd2);
        load(4'd3, 5'd3, DEB);
        load(4'd10, 5'd0, 4'd1);
        avancar = 1'b1;
        tick();
        avancar = 1'b0;
        chk("carga_cmd_ignored", 8'(linha), 8'd0);

        carga = 1'b0;
        tick();
        load(4'd2, 5'd0, 4'd1);
        chk("opera_anom", 8'(anomalia), 8'd0);

        girar = 1'b1;
        tick(); chk("gir1", 8'(orientacao), 8'd3);
        tick(); chk("gir2", 8'(orientacao), 8'd1);
        tick(); chk("gir3", 8'(orientacao), 8'd2);
        tick(); chk("gir4", 8'(orientacao), 8'd0);
        tick(); tick();
        girar = 1'b0;
        chk("ori_s", 8'(orientacao), 8'd1);
        chk("head_s", 8'(head), 8'd0);

        avancar = 1'b1; girar = 1'b1;
        tick();
        girar = 1'b0;
        chk("prio_linha", 8'(linha), 8'd1);
        chk("prio_ori", 8'(orientacao), 8'd1);
        chk("under_black", 8'(under), 8'd1);
        tick();
        chk("we_ignored_move", 8'(linha), 8'd2);
        chk("we_ignored_anom", 8'(anomalia), 8'd0);
        tick();
        avancar = 1'b0;
        chk("linha3", 8'(linha), 8'd3);
        chk("under_free", 8'(under), 8'd0);

        girar = 1'b1; tick(); girar = 1'b0;
        chk("ori_l", 8'(orientacao), 8'd2);
        chk("left_free", 8'(left), 8'd0);
        avancar = 1'b1; tick(); tick(); avancar = 1'b0;
        chk("col2", 8'(coluna), 8'd2);
        chk("head_deb", 8'(head), 8'd0);

`ifdef ROBO_AMBIENTE_ENTULHO_EN
        chk("barrier_on", 8'(barrier), 8'd1);
        remover = 1'b1; tick(); remover = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk("removendo_hi", 8'(removendo), 8'd1);
            tick();
        end
        chk("removendo_lo", 8'(removendo), 8'd0);
        chk("barrier_cleared", 8'(barrier), 8'd0);
`else
        chk("barrier_off", 8'(barrier), 8'd0);
        remover = 1'b1; tick(); remover = 1'b0;
        chk("remover_nop", 8'(removendo), 8'd0);
`endif
        chk("remove_pose", 8'(coluna), 8'd2);

        avancar = 1'b1;
        tick(); chk("onto_deb", 8'(coluna), 8'd3);
        tick(); tick();
        avancar = 1'b0;
        chk("col5", 8'(coluna), 8'd5);
        girar = 1'b1; tick(); girar = 1'b0;
        chk("ori_n", 8'(orientacao), 8'd0);
        chk("head_wall", 8'(head), 8'd1);
        chk("left_n", 8'(left), 8'd0);

        avancar = 1'b1; tick(); avancar = 1'b0;
        chk("anom_set", 8'(anomalia), 8'd1);
        chk("anom_linha", 8'(linha), 8'd3);
        chk("anom_head", 8'(head), 8'd1);

        carga = 1'b1; girar = 1'b1; tick();
        girar = 1'b0;
        chk("anom_carga", 8'(anomalia), 8'd1);
        chk("anom_ori", 8'(orientacao), 8'd0);
        chk("anom_col", 8'(coluna), 8'd5);

        #2 reset = 1'b0;
        #1;
        chk("async_anom", 8'(anomalia), 8'd0);
        chk("async_linha", 8'(linha), 8'd0);
        chk("async_coluna", 8'(coluna), 8'd0);
        reset = 1'b1;

`ifdef ROBO_AMBIENTE_ENTULHO_EN
        load(4'd0, 5'd1, 4'd4);
        carga = 1'b0;
        tick();
        girar = 1'b1; tick(); tick(); tick(); girar = 1'b0;
        chk("rm2_barrier", 8'(barrier), 8'd1);
        remover = 1'b1; tick(); remover = 1'b0;
        tick(); tick();
        chk("rm2_busy", 8'(removendo), 8'd1);
        #2 reset = 1'b0;
        #1;
        chk("rm2_rst_remov", 8'(removendo), 8'd0);
        chk("rm2_rst_ori", 8'(orientacao), 8'd0);
        reset = 1'b1;
        tick();
        girar = 1'b1; tick(); tick(); tick(); girar = 1'b0;
        chk("rm2_map_clear", 8'(barrier), 8'd0);
        chk("rm2_head", 8'(head), 8'd0);
`else
        carga = 1'b0;
        tick();
        chk("post_rst_anom", 8'(anomalia), 8'd0);
        girar = 1'b1; tick(); tick(); tick(); girar = 1'b0;
        chk("post_rst_head", 8'(head), 8'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/robo_ambiente.md
ROBO_AMBIENTE -- requirements
Module: robo_ambiente

Interface
REQ-001 Parameter LINHAS, default 10, number of map rows.
REQ-002 Parameter COLUNAS, default 20, number of map columns.
REQ-003 Parameter LIN_INI, default 0, robot start row.
REQ-004 Parameter COL_INI, default 0, robot start column.
REQ-005 Parameter ORI_INI, default 2'b00, robot start orientation (N=00, S=01, L=10, O=11).
REQ-006 Port clock  in  1  single clock, all state changes on its rising edge.
REQ-007 Port reset  in  1  asynchronous, active-low reset.
REQ-008 Port carga  in  1  map-load mode; high holds block in CARGA.
REQ-009 Port map_we, map_lin, map_col, map_dado  in  1/4/5/4  map cell write strobe, row, column, value.
REQ-010 Port avancar, girar, remover  in  1 each  robot commands.
REQ-011 Port head, left, under, barrier  out  1 each  sensors driven toward the robot.
REQ-012 Port linha, coluna, orientacao  out  4/5/2  current robot pose.
REQ-013 Port removendo  out  1  debris removal in progress.
REQ-014 Port anomalia  out  1  latched fault flag.

Function
REQ-015 Cell codes SHALL be: 0 free, 1 wall, 2 black cell, 3/4/5 light/medium/heavy debris; 6-15 SHALL be treated as free.
REQ-016 FSM states SHALL be CARGA, OPERA, REMOVE, ANOMALIA.
REQ-017 In CARGA: map_we writes map_dado to cell (map_lin, map_col); writes outside LINHAS x COLUNAS ignored; pose held at LIN_INI/COL_INI/ORI_INI; commands ignored.
REQ-018 CARGA -> OPERA on the first edge with carga low; if the start cell is 1, CARGA -> ANOMALIA instead.
REQ-019 map_we outside CARGA SHALL be ignored.
REQ-020 Front cell: N (lin-1,col), S (lin+1,col), L (lin,col+1), O (lin,col-1); left cell: N (lin,col-1), S (lin,col+1), L (lin-1,col), O (lin+1,col).
REQ-021 Sensors combinational from pose and map, zero latency: head = front off-map or front==1; left = left cell off-map or ==1; under = current cell==2; barrier = front on-map and 3..5.
REQ-022 In OPERA one command per cycle, priority avancar > girar > remover; others in that cycle dropped.
REQ-023 avancar with head=0 and barrier=0 moves one cell in orientation at next edge.
REQ-024 avancar with head=1 or barrier=1: pose unchanged, OPERA -> ANOMALIA.
REQ-025 girar rotates left at next edge: N->O, O->S, S->L, L->N; position unchanged.
REQ-026 remover with barrier=1 loads counter with 3/6/9 for code 3/4/5, captures front-cell address, OPERA -> REMOVE; remover with barrier=0 is a no-op.
REQ-027 In REMOVE: counter decrements once per cycle; all commands ignored; removendo=1; on the edge where counter goes 1 -> 0 the captured cell is written 0 and state returns to OPERA (removendo high exactly N cycles for life N).
REQ-028 ANOMALIA is terminal until reset; pose, map, sensors frozen; anomalia=1.
REQ-029 carga high in OPERA or REMOVE SHALL abort removal (cell unchanged) and enter CARGA; carga high in ANOMALIA ignored.

Reset
REQ-030 reset low SHALL asynchronously force state CARGA, all map cells 0, pose LIN_INI/COL_INI/ORI_INI, counter 0, removendo=0, anomalia=0.
REQ-031 Sensors after reset SHALL reflect the all-free map (only borders raise head/left).

Configuration
REQ-032 Macro ROBO_AMBIENTE_ENTULHO_EN: defined -> debris behaviour per REQ-021/026/027; undefined -> codes 3..5 treated as free, barrier tied 0, remover ignored, REMOVE state and counter not built, removendo tied 0.

Verification
REQ-033 Reset, load wall at (2,5), carga low, pose (3,5) N by load, avancar -> head=1 and anomalia=1 next cycle, linha stays 3.
REQ-034 Pose (0,0) orientation N after reset -> head=1, left=1, under=0, barrier=0.
REQ-035 Code 4 at (5,6), robot (5,5) L, remover one cycle -> removendo high 6 cycles, then cell (5,6)=0, barrier=0, avancar moves coluna to 6.
REQ-036 girar held 4 cycles from N -> orientacao O,S,L,N sequence; avancar+girar same cycle -> move only.
REQ-037 reset low mid-REMOVE (counter 4) -> immediately removendo=0, state CARGA, map all 0.
REQ-038 Build without ROBO_AMBIENTE_ENTULHO_EN, code 5 in front -> barrier=0, avancar moves onto cell, remover no effect.
